// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the SPI clock divider.
package clk_div_pkg;

  localparam int CLK_DIV_DEF_RATIO = 4;
  localparam int CLK_DIV_DEF_CNT_W = 8;

  typedef logic [CLK_DIV_DEF_CNT_W-1:0] clk_div_cnt_t;

  // Number of m_clk edges in one spi_clk half-period.
  function automatic int half_cnt(input int ratio);
    return ratio / 2;
  endfunction

endpackage

// File: rtl/clk_div_sync.sv
// Generic two-flop synchroniser; both flops load RST_VAL while rst_n is low.
module clk_div_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/clk_div.sv
// Even-ratio SPI clock divider gated by active-low chip select.
// Define CLK_DIV_CS_SYNC_EN to pass spi_cs through a 2-flop synchroniser first.
module clk_div
  import clk_div_pkg::*;
#(
  parameter int   DIV_RATIO = CLK_DIV_DEF_RATIO,
  parameter logic CPOL      = 1'b0,
  parameter int   CNT_W     = CLK_DIV_DEF_CNT_W
) (
  output logic spi_clk,
  input  logic m_clk,
  input  logic spi_cs,
  input  logic nrst
);

  localparam int               HALF    = half_cnt(DIV_RATIO);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(HALF - 1);

  if (DIV_RATIO < 2 || (DIV_RATIO % 2) != 0) begin : g_ratio_chk
    $error("clk_div: DIV_RATIO=%0d must be even and >= 2", DIV_RATIO);
  end

  if ((HALF - 1) >= (1 << CNT_W)) begin : g_width_chk
    $error("clk_div: CNT_W=%0d too narrow for DIV_RATIO=%0d", CNT_W, DIV_RATIO);
  end

  logic cs_eff;

`ifdef CLK_DIV_CS_SYNC_EN
  clk_div_sync #(
    .RST_VAL(1'b1)
  ) u_cs_sync (
    .clk  (m_clk),
    .rst_n(nrst),
    .d    (spi_cs),
    .q    (cs_eff)
  );
`else
  assign cs_eff = spi_cs;
`endif

  logic [CNT_W-1:0] cnt_p0;
  logic             clk_p0;

  // Half-period counter and toggle flop; chip select outranks the wrap.
  always_ff @(posedge m_clk or negedge nrst) begin
    if (!nrst) begin
      cnt_p0 <= '0;
      clk_p0 <= CPOL;
    end else if (cs_eff) begin
      cnt_p0 <= '0;
      clk_p0 <= CPOL;
    end else if (cnt_p0 == HALF_M1) begin
      cnt_p0 <= '0;
      clk_p0 <= ~clk_p0;
    end else begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  assign spi_clk = clk_p0;

endmodule

// File: tb/tb_clk_div.sv
// Scoreboard bench for clk_div: four configurations driven by shared clock, reset and cs.
module tb_clk_div;

  localparam int NI = 4;
  localparam int   HALF_A [NI] = '{2, 1, 5, 2};
  localparam logic CPOL_A [NI] = '{1'b0, 1'b0, 1'b0, 1'b1};
`ifdef CLK_DIV_CS_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic          m_clk  = 1'b0;
  logic          nrst   = 1'b1;
  logic          spi_cs = 1'b1;
  logic [NI-1:0] spi_clk;

  always #50 m_clk = ~m_clk;

  clk_div #(.DIV_RATIO(4),  .CPOL(1'b0)) u_d4  (.spi_clk(spi_clk[0]), .m_clk(m_clk), .spi_cs(spi_cs), .nrst(nrst));
  clk_div #(.DIV_RATIO(2),  .CPOL(1'b0)) u_d2  (.spi_clk(spi_clk[1]), .m_clk(m_clk), .spi_cs(spi_cs), .nrst(nrst));
  clk_div #(.DIV_RATIO(10), .CPOL(1'b0)) u_d10 (.spi_clk(spi_clk[2]), .m_clk(m_clk), .spi_cs(spi_cs), .nrst(nrst));
  clk_div #(.DIV_RATIO(4),  .CPOL(1'b1)) u_p1  (.spi_clk(spi_clk[3]), .m_clk(m_clk), .spi_cs(spi_cs), .nrst(nrst));

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: active edges since effective cs went low, plus cs delay line.
  int            n_act = 0;
  logic          s1    = 1'b1;
  logic          s2    = 1'b1;
  logic [NI-1:0] last_e;
  logic [NI-1:0] sb_q [$];

  task automatic check_eq(input string tag, input logic got, input logic exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t ns: spi_clk=%b expected %b", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    n_act = 0;
    s1    = 1'b1;
    s2    = 1'b1;
  endtask

  // Expected spi_clk of every instance after the coming rising edge.
  task automatic predict(input logic cs, output logic [NI-1:0] e);
    logic eff;
    if (!nrst) begin
      model_reset();
    end else begin
      eff = (LAT == 2) ? s2 : cs;
      s2  = s1;
      s1  = cs;
      if (eff) n_act = 0;
      else     n_act++;
    end
    for (int i = 0; i < NI; i++)
      e[i] = CPOL_A[i] ^ (((n_act / HALF_A[i]) % 2) == 1);
  endtask

  // Called at a falling edge: drive cs, push expectation, compare after the rising edge.
  task automatic step(input logic cs, input string tag);
    logic [NI-1:0] e;
    spi_cs = cs;
    predict(cs, e);
    sb_q.push_back(e);
    @(posedge m_clk);
    #1;
    e = sb_q.pop_front();
    last_e = e;
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("%s.u%0d", tag, i), spi_clk[i], e[i]);
    @(negedge m_clk);
  endtask

  initial begin
    logic cs_r;
    int   guard;

    #5 nrst = 1'b0;
    #5;
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("rst_async.u%0d", i), spi_clk[i], CPOL_A[i]);
    @(negedge m_clk);
    for (int k = 0; k < 3; k++) step(1'b1, "rst_hold");

    nrst = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b1, "idle");

    for (int k = 0; k < 50; k++) step(1'b0, "run");

    // Mid-run reset while the DIV_RATIO=4 output is high.
    guard = 0;
    while (last_e[0] !== 1'b1 && guard < 10) begin
      step(1'b0, "to_high");
      guard++;
    end
    check_eq("reach_high", spi_clk[0], 1'b1);
    #10 nrst = 1'b0;
    #1;
    for (int i = 0; i < NI; i++)
      check_eq($sformatf("rst_mid.u%0d", i), spi_clk[i], CPOL_A[i]);
    model_reset();
    @(negedge m_clk);
    for (int k = 0; k < 2; k++) step(1'b0, "rst_pulse");
    nrst = 1'b1;
    for (int k = 0; k < 14; k++) step(1'b0, "restart");

    // Chip select dropped one cycle into a high phase.
    guard = 0;
    while (last_e[0] !== 1'b1 && guard < 10) begin
      step(1'b0, "abort_pre");
      guard++;
    end
    step(1'b0, "abort_high");
    for (int k = 0; k < 4; k++) step(1'b1, "abort");
    for (int k = 0; k < 14; k++) step(1'b0, "reassert");

    // Random chip-select runs.
    cs_r = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) cs_r = ~cs_r;
      step(cs_r, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
